// File: rtl/siganfu_fire_arbiter.sv
// Round-robin fire-control arbiter: one console owns the gun at a time, and its
// requests become spaced trigger pulses, with burst limits, cooldown and overheat hold.
module siganfu_fire_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 8,
  parameter int SHOT_GAP  = 5,
  parameter int COOLDOWN  = 10
) (
  input  logic             sysclk,
  input  logic             reboot,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_mode,
  input  logic             gun_ready,
  input  logic             overheat_sensor,
  output logic [N_REQ-1:0] grant,
  output logic             fire_trigger,
  output logic [2:0]       current_state,
  output logic [3:0]       shot_count
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX = (SHOT_GAP > COOLDOWN) ? SHOT_GAP : COOLDOWN;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    GAP  = 3'd3,
    COOL = 3'd4,
    HOLD = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             fire_q, fire_d;
  logic [3:0]       shot_q, shot_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic             found;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    winner_next;
  logic             owner_req;
  int               idx;

  // Scan upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign winner_next = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
  assign owner_req   = req[owner_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    fire_d  = 1'b0;
    shot_d  = shot_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (found && gun_ready && !overheat_sensor) begin
          state_d         = ARM;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          mode_d          = req_mode[winner];
          shot_d          = 4'd0;
          ptr_d           = winner_next;
        end
      end
      ARM: begin
        if (overheat_sensor) begin
          state_d = HOLD;
          grant_d = '0;
        end else if (!owner_req) begin
          state_d = COOL;
          grant_d = '0;
          cnt_d   = CW'(COOLDOWN);
        end else if (gun_ready) begin
          state_d = FIRE;
          fire_d  = 1'b1;
          shot_d  = shot_q + 4'd1;
        end
      end
      FIRE: begin
        if (overheat_sensor) begin
          state_d = HOLD;
          grant_d = '0;
        end else if (!mode_q || shot_q == 4'(BURST_MAX) || !owner_req) begin
          state_d = COOL;
          grant_d = '0;
          cnt_d   = CW'(COOLDOWN);
        end else begin
          state_d = GAP;
          cnt_d   = CW'(SHOT_GAP - 1);
        end
      end
      GAP: begin
        // The shot fires on the edge where the count would reach zero, so
        // pulses land exactly SHOT_GAP cycles apart; a busy gun parks at zero.
        if (overheat_sensor) begin
          state_d = HOLD;
          grant_d = '0;
        end else if (!owner_req) begin
          state_d = COOL;
          grant_d = '0;
          cnt_d   = CW'(COOLDOWN);
        end else if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else if (gun_ready) begin
          state_d = FIRE;
          fire_d  = 1'b1;
          shot_d  = shot_q + 4'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      COOL: begin
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (!overheat_sensor) begin
          state_d = COOL;
          cnt_d   = CW'(COOLDOWN);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reboot) begin
    if (reboot) begin
      state_q <= IDLE;
      grant_q <= '0;
      fire_q  <= 1'b0;
      shot_q  <= 4'd0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      fire_q  <= fire_d;
      shot_q  <= shot_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign grant         = grant_q;
  assign fire_trigger  = fire_q;
  assign current_state = state_q;
  assign shot_count    = shot_q;

endmodule
